wb_uart_rx: RTL and testbench

//  UART receive stage behind the user-area Wishbone decode at 0x3000_0000 (the decoder gates stb/cyc, so only adr[7:0] is used here).
//  - Deserialises 8N1 frames from an IO pad into a FIFO.
//  - Exposes data, status, control and baud registers to firmware.
//  - Raises one level-sensitive interrupt.

---
 rtl/wb_uart_rx.sv | 254 +++++++++++++++++++++++++
 tb/tb_wb_uart_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_rx.sv
// Wishbone-attached 8N1 UART receiver with RX FIFO, status/control/baud
// registers and a single level interrupt.
module wb_uart_rx #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 433
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        rx_i,
  output logic        irq_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [5:0] AdrRxData  = 6'd0;
  localparam logic [5:0] AdrStatus  = 6'd1;
  localparam logic [5:0] AdrCtrl    = 6'd2;
  localparam logic [5:0] AdrBaudDiv = 6'd3;

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  // Bus request capture
  logic        ack_q;
  logic [5:0]  adr_q;
  logic        we_q;
  logic [15:0] wdat_q;
  logic        req;

  // Registers
  logic        rx_en_q, irq_en_q, ovr_q, fe_q, irq_q;
  logic [15:0] div_q;
  logic [15:0] eff_div;

  // Synchroniser
  logic rx_s1_q, rx_s2_q;

  // FSM
  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        push_q;
  logic [7:0]  push_byte_q;
  logic        fe_set_q;

  // FIFO
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            not_empty, full, pop, flush, push_ok, ovr_set;

  // Access decode, all effective in the ack cycle
  logic rd_acc, wr_acc;
  logic [31:0] rdata;

  logic unused;
  assign unused = ^{wbs_sel_i, wbs_adr_i[31:8], wbs_adr_i[1:0], wbs_dat_i[31:16]};

  assign req    = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign rd_acc = ack_q & ~we_q;
  assign wr_acc = ack_q & we_q;

  assign eff_div   = (div_q < 16'd3) ? 16'd3 : div_q;
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign pop       = rd_acc & (adr_q == AdrRxData) & not_empty;
  assign flush     = wr_acc & (adr_q == AdrCtrl) & wdat_q[2];
  assign push_ok   = push_q & ~flush & (~full | pop);
  assign ovr_set   = push_q & ~flush & full & ~pop;

  // Latch the request so the ack cycle sees a stable address/data
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q  <= 1'b0;
      adr_q  <= '0;
      we_q   <= 1'b0;
      wdat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) begin
        adr_q  <= wbs_adr_i[7:2];
        we_q   <= wbs_we_i;
        wdat_q <= wbs_dat_i[15:0];
      end
    end
  end

  // Read data mux
  always_comb begin
    rdata = '0;
    case (adr_q)
      AdrRxData:  rdata = not_empty ? {1'b1, 23'b0, mem_q[rd_ptr_q]} : 32'd0;
      AdrStatus:  rdata = {16'b0, 8'(count_q), 4'b0, fe_q, ovr_q, full, not_empty};
      AdrCtrl:    rdata = {30'b0, irq_en_q, rx_en_q};
      AdrBaudDiv: rdata = {16'b0, div_q};
      default:    rdata = '0;
    endcase
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rd_acc ? rdata : 32'd0;
  assign irq_o     = irq_q;

  // Control, baud, sticky flags and registered interrupt
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_en_q  <= 1'b0;
      irq_en_q <= 1'b0;
      div_q    <= 16'(DEFAULT_DIV);
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_acc && adr_q == AdrCtrl) begin
        rx_en_q  <= wdat_q[0];
        irq_en_q <= wdat_q[1];
      end
      if (wr_acc && adr_q == AdrBaudDiv) begin
        div_q <= wdat_q;
      end
      // A new event in the same cycle as a W1C keeps the flag set
      ovr_q <= (ovr_q & ~(wr_acc & (adr_q == AdrStatus) & wdat_q[2])) | ovr_set;
      fe_q  <= (fe_q & ~(wr_acc & (adr_q == AdrStatus) & wdat_q[3])) | fe_set_q;
      irq_q <= irq_en_q & (not_empty | ovr_q | fe_q);
    end
  end

  // Two-flop synchroniser for the pad input
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= rx_i;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Receive FSM; push and frame-error strobes are registered one-cycle pulses
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      fe_set_q    <= 1'b0;
    end else begin
      push_q   <= 1'b0;
      fe_set_q <= 1'b0;
      if (!rx_en_q) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s2_q) begin
              state_q <= StStart;
              cnt_q   <= eff_div >> 1;
            end
          end
          StStart: begin
            if (cnt_q == '0) begin
              if (!rx_s2_q) begin
                state_q <= StData;
                bit_q   <= '0;
                cnt_q   <= eff_div;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          StData: begin
            if (cnt_q == '0) begin
              shift_q <= {rx_s2_q, shift_q[7:1]};
              cnt_q   <= eff_div;
              if (bit_q == 3'd7) begin
                state_q <= StStop;
              end else begin
                bit_q <= bit_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          StStop: begin
            if (cnt_q == '0) begin
              if (rx_s2_q) begin
                push_q      <= 1'b1;
                push_byte_q <= shift_q;
                state_q     <= StIdle;
              end else begin
                fe_set_q <= 1'b1;
                state_q  <= StBreak;
              end
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          StBreak: begin
            if (rx_s2_q) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // FIFO pointer/count next state; flush overrides push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop);
    end
  end

  // FIFO state
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte_q;
  end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed bench for wb_uart_rx: bus access, framing, FIFO limits, irq, reset.
module tb_wb_uart_rx;

  localparam int BitClks = 4;  // BAUDDIV=3 -> 4 clocks per bit

  logic        clk;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        rx;
  logic        irq;

  int checks = 0;
  int errors = 0;

  wb_uart_rx #(
    .FIFO_DEPTH (16),
    .DEFAULT_DIV(433)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(wdat),
    .wbs_ack_o(ack),
    .wbs_dat_o(rdat),
    .rx_i     (rx),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic w, input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] r);
    stb  = 1'b1;
    cyc  = 1'b1;
    we   = w;
    adr  = 32'h3000_0000 | {24'b0, a};
    wdat = d;
    tick(1);
    check_eq("ack", {31'b0, ack}, 32'd1);
    r = rdat;
    tick(1);
    check_eq("ack_drop", {31'b0, ack}, 32'd0);
    stb = 1'b0;
    cyc = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb_xfer(1'b0, a, 32'd0, r);
    check_eq(tag, r, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
    rx = 1'b0;
    tick(BitClks);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(BitClks);
    end
    rx = stop_lvl;
    tick(BitClks);
    rx = 1'b1;
    tick(2 * BitClks);
  endtask

  initial begin
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF; adr = '0; wdat = '0;
    rx = 1'b1;
    rst_n = 1'b0;
    tick(3);
    check_eq("rst_ack", {31'b0, ack}, 32'd0);
    check_eq("rst_dat", rdat, 32'd0);
    check_eq("rst_irq", {31'b0, irq}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    rd_check("rst_status", 8'h04, 32'h0);
    rd_check("rst_baud", 8'h0C, 32'd433);
    rd_check("rst_ctrl", 8'h08, 32'h0);
    rd_check("unmapped", 8'h40, 32'h0);

    // 1: single byte
    wb_write(8'h0C, 32'd3);
    wb_write(8'h08, 32'h1);
    rd_check("ctrl_rb", 8'h08, 32'h1);
    send_frame(8'hA5, 1'b1);
    rd_check("t1_status", 8'h04, 32'h0000_0101);
    check_eq("t1_irq_off", {31'b0, irq}, 32'd0);
    rd_check("t1_data", 8'h00, 32'h8000_00A5);
    rd_check("t1_status2", 8'h04, 32'h0);

    // 2: overflow with 17 bytes
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    rd_check("t2_status", 8'h04, 32'h0000_1007);
    for (int i = 0; i < 16; i++) rd_check("t2_data", 8'h00, 32'h8000_0000 | i);
    rd_check("t2_status_ovr", 8'h04, 32'h0000_0004);
    wb_write(8'h04, 32'h4);
    rd_check("t2_status_clr", 8'h04, 32'h0);

    // 3: framing error
    send_frame(8'h00, 1'b0);
    rd_check("t3_status", 8'h04, 32'h0000_0008);
    wb_write(8'h04, 32'h8);
    rd_check("t3_status_clr", 8'h04, 32'h0);

    // 4: one-clock glitch
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(20);
    rd_check("t4_empty_rd", 8'h00, 32'h0);
    rd_check("t4_status", 8'h04, 32'h0);

    // 5: interrupt
    wb_write(8'h08, 32'h3);
    send_frame(8'h3C, 1'b1);
    check_eq("t5_irq_on", {31'b0, irq}, 32'd1);
    rd_check("t5_data", 8'h00, 32'h8000_003C);
    check_eq("t5_irq_hold", {31'b0, irq}, 32'd1);
    tick(1);
    check_eq("t5_irq_off", {31'b0, irq}, 32'd0);

    // 6: disable mid-byte, then re-enable and receive
    wb_write(8'h08, 32'h1);
    rx = 1'b0;
    tick(12);
    wb_write(8'h08, 32'h0);
    tick(2);
    rx = 1'b1;
    tick(20);
    rd_check("t6_status_dis", 8'h04, 32'h0);
    wb_write(8'h08, 32'h1);
    send_frame(8'h5A, 1'b1);
    rd_check("t6_status", 8'h04, 32'h0000_0101);

    // Reset during the ack cycle of an RXDATA read
    stb = 1'b1;
    cyc = 1'b1;
    we  = 1'b0;
    adr = 32'h3000_0000;
    tick(1);
    check_eq("t6_ack_pre", {31'b0, ack}, 32'd1);
    check_eq("t6_dat_pre", rdat, 32'h8000_005A);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_ack", {31'b0, ack}, 32'd0);
    check_eq("t6_rst_dat", rdat, 32'd0);
    stb = 1'b0;
    cyc = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    rd_check("t6_rst_status", 8'h04, 32'h0);
    rd_check("t6_rst_baud", 8'h0C, 32'd433);
    rd_check("t6_rst_ctrl", 8'h08, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
